wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Two-master, one-slave Wishbone arbiter sharing the 4-bit-address / 8-bit-data register bus between the DCF77 host-interface master (m0) and the decoder-update master (m1). Arbitration is round-robin and locked per bus cycle: a grant is held until the owning master drops `cyc`. Slave-side signals are muxed from a registered grant, so the slave sees exactly one master at a time.

## Interface
- `addr_width`, default 4: address width of every port.
- `data_width`, default 8: data width of every port.
- `TIMEOUT`, default 255: watchdog limit in clk cycles; used only with `WB_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `m0_addr`, `m1_addr` in `addr_width`: master addresses.
- `m0_data_m`, `m1_data_m` in `data_width`: master write data.
- `m0_cyc`/`m0_stb`/`m0_we`, `m1_cyc`/`m1_stb`/`m1_we` in 1 each: master controls.
- `m0_data_s`, `m1_data_s` out `data_width`: read data to the masters.
- `m0_ack`, `m1_ack` out 1: acknowledges to the masters.
- `s_addr` out `addr_width`, `s_data_m` out `data_width`, `s_cyc`/`s_stb`/`s_we` out 1: slave side.
- `s_data_s` in `data_width`, `s_ack` in 1: slave response.
- `gnt` out 2: one-hot current owner; `2'b00` means idle.
- `timeout` out 1: one-cycle pulse on a watchdog abort. Present only with `WB_ARB_TIMEOUT_EN`.

## Operation
- FSM states: `IDLE`, `OWN0`, `OWN1`. Reset state is `IDLE`, with `last` = 1 so that m0 wins the first tie.
- In `IDLE`, only `cyc` counts as a request:
  - one requester: go to its `OWNx`;
  - both requesting: grant the master that is not `last`.
- Entering `OWNx` sets `last` = x.
- In `OWNx`:
  - `s_*` outputs = `mx_*` inputs (combinational mux on the registered state);
  - `mx_data_s` = `s_data_s`, `mx_ack` = `s_ack`.
- The master that is not granted sees `data_s` = 0 and `ack` = 0. In `IDLE`, `s_cyc` = `s_stb` = `s_we` = 0, `s_addr` = 0 and `s_data_m` = 0.
- `OWNx` goes to `IDLE` when `mx_cyc` = 0. `OWNx` is never left directly for the other `OWNy`: a hand-over always passes through `IDLE`.
- Grant changes never happen while the owner holds `cyc`, so multi-beat cycles are atomic.
- `gnt` = {state==`OWN1`, state==`OWN0`}.
- Reset asserted mid-cycle forces `IDLE` immediately. The slave-side controls go to 0 asynchronously and any in-flight transfer is dropped.

## Timing
- Reset values: every output is 0, state is `IDLE`, `last` = 1.
- Grant latency: `cyc` sampled high in `IDLE` at edge N gives an owned state from edge N onward. The slave sees `s_cyc`/`s_stb` in cycle N+1, i.e. one cycle after the request.
- Data path latency: zero cycles. `s_ack` passes through to `mx_ack` combinationally.
- Release: the owner drops `cyc` → `IDLE` at the next edge. The earliest cycle in which the other master can be owned is one cycle later.
- Minimum hand-over gap between back-to-back owners: 1 idle cycle.
- Starvation bound: a requester waits at most one complete cycle of the other master.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - an 8-bit-or-wider counter resets to 0 on entry to `OWNx` and on each `s_ack`;
  - it counts while `mx_stb` = 1 and `s_ack` = 0;
  - when it reaches `TIMEOUT`, the arbiter drives `mx_ack` = 1 with `mx_data_s` = 0 for one cycle, pulses `timeout`, forces `s_cyc` = 0 and returns to `IDLE`.
- `WB_ARB_TIMEOUT_EN` not defined: no counter and no `timeout` port. A slave that never acks hangs the bus.

## Structure
- Put `arb_state_t` (enum `IDLE`/`OWN0`/`OWN1`) in the shared `types` package. The watchdog counter width, derived from `TIMEOUT`, also goes there as a constant.
- One sub-module, `wb_arb_watchdog`, holds the counter and the `expired` flag. It is instantiated only under `WB_ARB_TIMEOUT_EN`.

## Test plan
- Reset: hold `rst` = 0 with both `cyc` = 1 → `gnt` = 00 and all `s_*` = 0. Release → `gnt` = 01 after the first edge.
- Single read by m1: addr 4'h3, `s_data_s` = 8'hA5, slave acks in cycle 2 → `m1_data_s` = 8'hA5 with `m1_ack` = 1 in that cycle, and `m0_ack` stays 0.
- Contention: both masters hold `cyc` continuously for 3-beat cycles → grants alternate 01, 00, 10, 00, 01, with the 1-cycle idle gap each time.
- Locking: m0 owns the bus and m1 raises `cyc` mid-transfer → `gnt` stays 01 until `m0_cyc` falls, then shows 00, then 10.
- Reset mid-transfer: `rst` pulled low while `OWN1` with `stb` = 1 → `s_stb` = 0 asynchronously, state returns to `IDLE`, and m0 wins the next tie.
- With `WB_ARB_TIMEOUT_EN` and `TIMEOUT` = 4: slave never acks → exactly 4 stalled cycles, then `m0_ack` = 1 with data 8'h00, a 1-cycle `timeout` pulse, and `gnt` = 00.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arbiter_pkg;

  // Bus ownership: nobody, master 0 or master 1.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Default watchdog limit in clk cycles.
  localparam int unsigned WB_ARB_TIMEOUT_DEFAULT = 255;

  // Watchdog counter width: wide enough to hold the limit, never below 8 bits.
  function automatic int unsigned wdog_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 8) ? 8 : w;
  endfunction

  localparam int unsigned WDOG_CNT_W = wdog_width(WB_ARB_TIMEOUT_DEFAULT);

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog for the arbiter: counts owner strobe cycles without an ack
// and flags expiry once the count reaches TIMEOUT.
module wb_arb_watchdog
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = WB_ARB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_stb,
  input  logic i_ack,
  output logic o_expired
);

  localparam int unsigned CNT_W = wdog_width(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  // Counter clears while idle (so it is 0 on every grant), on ack and on
  // expiry; otherwise it advances on each unacknowledged strobe cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!i_active || i_ack || o_expired) begin
      r_cnt <= '0;
    end else if (i_stb) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Expiry is only meaningful while a master owns the bus.
  always_comb begin
    o_expired = i_active && (r_cnt == CNT_W'(TIMEOUT));
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master / one-slave Wishbone arbiter, round-robin, locked per bus cycle.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned addr_width = 4,
  parameter int unsigned data_width = 8,
  parameter int unsigned TIMEOUT    = WB_ARB_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_width-1:0] m0_addr,
  input  logic [data_width-1:0] m0_data_m,
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [addr_width-1:0] m1_addr,
  input  logic [data_width-1:0] m1_data_m,
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  output logic [data_width-1:0] m0_data_s,
  output logic                  m0_ack,
  output logic [data_width-1:0] m1_data_s,
  output logic                  m1_ack,
  output logic [addr_width-1:0] s_addr,
  output logic [data_width-1:0] s_data_m,
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  input  logic [data_width-1:0] s_data_s,
  input  logic                  s_ack,
  output logic [1:0]            gnt
`ifdef WB_ARB_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_last;
  logic       w_expired;

`ifdef WB_ARB_TIMEOUT_EN
  logic w_active;
  logic w_owner_stb;

  assign w_active    = (r_state != IDLE);
  assign w_owner_stb = (r_state == OWN1) ? m1_stb : m0_stb;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_active  (w_active),
    .i_stb     (w_owner_stb),
    .i_ack     (s_ack),
    .o_expired (w_expired)
  );

  assign timeout = w_expired;
`else
  logic w_unused_timeout;

  assign w_expired        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  // State and round-robin history; last records the most recent owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == OWN0) begin
        r_last <= 1'b0;
      end else if (r_state == IDLE && w_next == OWN1) begin
        r_last <= 1'b1;
      end
    end
  end

  // Grant only from IDLE; an owner keeps the bus until it drops cyc.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          w_next = r_last ? OWN0 : OWN1;
        end else if (m0_cyc) begin
          w_next = OWN0;
        end else if (m1_cyc) begin
          w_next = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc || w_expired) begin
          w_next = IDLE;
        end
      end
      OWN1: begin
        if (!m1_cyc || w_expired) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Bus mux from the registered state; a watchdog abort fakes an ack with
  // zero data to the owner and withdraws cyc from the slave.
  always_comb begin
    s_addr    = '0;
    s_data_m  = '0;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    m0_data_s = '0;
    m0_ack    = 1'b0;
    m1_data_s = '0;
    m1_ack    = 1'b0;
    gnt       = {r_state == OWN1, r_state == OWN0};
    unique case (r_state)
      OWN0: begin
        s_addr    = m0_addr;
        s_data_m  = m0_data_m;
        s_cyc     = m0_cyc && !w_expired;
        s_stb     = m0_stb;
        s_we      = m0_we;
        m0_data_s = w_expired ? '0 : s_data_s;
        m0_ack    = s_ack || w_expired;
      end
      OWN1: begin
        s_addr    = m1_addr;
        s_data_m  = m1_data_m;
        s_cyc     = m1_cyc && !w_expired;
        s_stb     = m1_stb;
        s_we      = m1_we;
        m1_data_s = w_expired ? '0 : s_data_s;
        m1_ack    = s_ack || w_expired;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (default build or WB_ARB_TIMEOUT_EN).
module tb_wb_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_data_m = '0, m1_data_m = '0;
  logic          m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic          m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [DW-1:0] s_data_s = '0;
  logic          s_ack = 1'b0;
  logic [DW-1:0] m0_data_s, m1_data_s, s_data_m;
  logic          m0_ack, m1_ack, s_cyc, s_stb, s_we;
  logic [AW-1:0] s_addr;
  logic [1:0]    gnt;
  logic          tmo;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner (-1 none), last owner, stalled-cycle count.
  int mo = -1;
  int ml = 1;
  int mcnt = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .addr_width (AW),
    .data_width (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_addr   (m0_addr),
    .m0_data_m (m0_data_m),
    .m0_cyc    (m0_cyc),
    .m0_stb    (m0_stb),
    .m0_we     (m0_we),
    .m1_addr   (m1_addr),
    .m1_data_m (m1_data_m),
    .m1_cyc    (m1_cyc),
    .m1_stb    (m1_stb),
    .m1_we     (m1_we),
    .m0_data_s (m0_data_s),
    .m0_ack    (m0_ack),
    .m1_data_s (m1_data_s),
    .m1_ack    (m1_ack),
    .s_addr    (s_addr),
    .s_data_m  (s_data_m),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_we      (s_we),
    .s_data_s  (s_data_s),
    .s_ack     (s_ack),
    .gnt       (gnt)
`ifdef WB_ARB_TIMEOUT_EN
    ,
    .timeout   (tmo)
`endif
  );

`ifndef WB_ARB_TIMEOUT_EN
  assign tmo = 1'b0;
`endif

  function automatic void model_reset();
    mo = -1;
    ml = 1;
    mcnt = 0;
  endfunction

  function automatic bit model_expired();
`ifdef WB_ARB_TIMEOUT_EN
    return (mo >= 0) && (mcnt == int'(TO));
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model by one rising edge using the inputs held before it.
  function automatic void model_edge();
    bit ex, cyc, stb;
    if (!rst) begin
      model_reset();
      return;
    end
    ex = model_expired();
    if (mo < 0) begin
      if (m0_cyc && m1_cyc) mo = (ml == 1) ? 0 : 1;
      else if (m0_cyc)      mo = 0;
      else if (m1_cyc)      mo = 1;
      if (mo >= 0) ml = mo;
      mcnt = 0;
    end else begin
      cyc = (mo == 0) ? m0_cyc : m1_cyc;
      stb = (mo == 0) ? m0_stb : m1_stb;
      if (ex || !cyc) begin
        mo = -1;
        mcnt = 0;
      end else if (s_ack) begin
        mcnt = 0;
      end else if (stb) begin
        mcnt++;
      end
    end
  endfunction

  function automatic logic [35:0] exp_vec();
    logic [1:0]    g;
    logic          sc, ss, sw, a0, a1, ex;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd, d0, d1;
    g = 2'b00; sc = 0; ss = 0; sw = 0; a0 = 0; a1 = 0;
    sa = '0; sd = '0; d0 = '0; d1 = '0;
    ex = model_expired();
    if (mo == 0) begin
      g = 2'b01; sc = m0_cyc && !ex; ss = m0_stb; sw = m0_we;
      sa = m0_addr; sd = m0_data_m; a0 = s_ack || ex; d0 = ex ? '0 : s_data_s;
    end else if (mo == 1) begin
      g = 2'b10; sc = m1_cyc && !ex; ss = m1_stb; sw = m1_we;
      sa = m1_addr; sd = m1_data_m; a1 = s_ack || ex; d1 = ex ? '0 : s_data_s;
    end
    return {g, sc, ss, sw, sa, sd, a0, d0, a1, d1, ex};
  endfunction

  function automatic logic [35:0] act_vec();
    return {gnt, s_cyc, s_stb, s_we, s_addr, s_data_m,
            m0_ack, m0_data_s, m1_ack, m1_data_s, tmo};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = '0; m0_data_m = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = '0; m1_data_m = '0;
    s_ack = 0; s_data_s = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    model_reset();
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    model_reset();
    m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1; m0_we = 1; m1_we = 1;
    m0_addr = 4'hA; m1_addr = 4'h5; m0_data_m = 8'h3C; m1_data_m = 8'hC3;
    s_ack = 1; s_data_s = 8'hFF;
    #2;
    n_cmp++;
    if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt got %b exp 00", gnt); end
    n_cmp++;
    if ({s_cyc, s_stb, s_we, s_addr, s_data_m} !== '0) begin
      n_bad++; $display("FAIL reset_slave got %b%b%b %h %h exp all 0", s_cyc, s_stb, s_we, s_addr, s_data_m);
    end
    n_cmp++;
    if ({m0_ack, m1_ack, m0_data_s, m1_data_s} !== '0) begin
      n_bad++; $display("FAIL reset_master got ack %b%b data %h %h exp 0", m0_ack, m1_ack, m0_data_s, m1_data_s);
    end
    tick();
    tick();
    rst = 1;
    #2;
    n_cmp++;
    if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_release_gnt got %b exp 00", gnt); end
    tick();
    n_cmp++;
    if (gnt !== 2'b01 || s_addr !== 4'hA) begin
      n_bad++; $display("FAIL reset_first_tie got gnt %b addr %h exp 01 a", gnt, s_addr);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 4'h3;
    #2;
    n_cmp++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0) begin
      n_bad++; $display("FAIL read_req_cycle got gnt %b s_cyc %b exp 00 0", gnt, s_cyc);
    end
    tick();
    s_ack = 0;
    #2;
    n_cmp++;
    if ({s_cyc, s_stb, s_we, s_addr, m1_ack} !== {1'b1, 1'b1, 1'b0, 4'h3, 1'b0}) begin
      n_bad++; $display("FAIL read_cycle1 got cyc %b stb %b we %b addr %h ack %b exp 1 1 0 3 0", s_cyc, s_stb, s_we, s_addr, m1_ack);
    end
    tick();
    s_ack = 1; s_data_s = 8'hA5;
    #2;
    n_cmp++;
    if (m1_data_s !== 8'hA5 || m1_ack !== 1'b1) begin
      n_bad++; $display("FAIL read_data got %h ack %b exp a5 1", m1_data_s, m1_ack);
    end
    n_cmp++;
    if (m0_ack !== 1'b0 || m0_data_s !== 8'h00) begin
      n_bad++; $display("FAIL read_other_master got ack %b data %h exp 0 00", m0_ack, m0_data_s);
    end
    tick();
    idle_inputs();
    tick();
    #2;
    n_cmp++;
    if (gnt !== 2'b00) begin n_bad++; $display("FAIL read_release got %b exp 00", gnt); end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] hist[$];
    logic [1:0] rv[$];
    int         rl[$];
    logic [1:0] ev[8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    int         el[8] = '{1, 4, 1, 4, 1, 4, 1, 4};
    int         b0 = 0, b1 = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (b0 == 3) begin m0_cyc = 0; m0_stb = 0; b0 = 0; end
      else begin m0_cyc = 1; m0_stb = 1; end
      if (b1 == 3) begin m1_cyc = 0; m1_stb = 0; b1 = 0; end
      else begin m1_cyc = 1; m1_stb = 1; end
      #1;
      s_ack = s_cyc && s_stb;
      s_data_s = 8'($urandom);
      #1;
      hist.push_back(gnt);
      if (m0_ack) b0++;
      if (m1_ack) b1++;
      tick();
    end
    foreach (hist[i]) begin
      if (rv.size() != 0 && rv[rv.size()-1] === hist[i]) rl[rl.size()-1]++;
      else begin rv.push_back(hist[i]); rl.push_back(1); end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= rv.size()) begin
        n_bad++; $display("FAIL contention_run%0d got none exp %b x%0d", i, ev[i], el[i]);
      end else if (rv[i] !== ev[i] || rl[i] != el[i]) begin
        n_bad++; $display("FAIL contention_run%0d got %b x%0d exp %b x%0d", i, rv[i], rl[i], ev[i], el[i]);
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_locking();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_addr = 4'h7; s_ack = 1;
    tick();
    #2;
    n_cmp++;
    if (gnt !== 2'b01) begin n_bad++; $display("FAIL lock_grant got %b exp 01", gnt); end
    m1_cyc = 1; m1_stb = 1; m1_addr = 4'h9;
    for (int k = 0; k < 3; k++) begin
      tick();
      #2;
      n_cmp++;
      if (gnt !== 2'b01) begin n_bad++; $display("FAIL lock_hold%0d got %b exp 01", k, gnt); end
    end
    m0_cyc = 0; m0_stb = 0;
    #1;
    n_cmp++;
    if (gnt !== 2'b01 || s_cyc !== 1'b0) begin
      n_bad++; $display("FAIL lock_drop got gnt %b s_cyc %b exp 01 0", gnt, s_cyc);
    end
    tick();
    #2;
    n_cmp++;
    if (gnt !== 2'b00) begin n_bad++; $display("FAIL lock_gap got %b exp 00", gnt); end
    tick();
    #2;
    n_cmp++;
    if (gnt !== 2'b10 || s_addr !== 4'h9) begin
      n_bad++; $display("FAIL lock_handover got gnt %b addr %h exp 10 9", gnt, s_addr);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 4'h6;
    tick();
    #2;
    n_cmp++;
    if (s_stb !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre got s_stb %b exp 1", s_stb); end
    #1;
    rst = 0;
    model_reset();
    #1;
    n_cmp++;
    if ({s_stb, s_cyc, s_we, gnt} !== 5'b0) begin
      n_bad++; $display("FAIL rstmid_async got stb %b cyc %b we %b gnt %b exp 0 0 0 00", s_stb, s_cyc, s_we, gnt);
    end
    m0_cyc = 1; m0_stb = 1;
    tick();
    rst = 1;
    tick();
    #2;
    n_cmp++;
    if (gnt !== 2'b01) begin n_bad++; $display("FAIL rstmid_tie1 got %b exp 01", gnt); end
    // m0 is now the last owner; a reset must still hand the next tie to m0.
    rst = 0;
    model_reset();
    tick();
    rst = 1;
    tick();
    #2;
    n_cmp++;
    if (gnt !== 2'b01) begin n_bad++; $display("FAIL rstmid_tie2 got %b exp 01", gnt); end
    idle_inputs();
    tick();
    tick();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 4'h2; s_ack = 0; s_data_s = 8'hFF;
    tick();
    for (int k = 0; k < 4; k++) begin
      #2;
      n_cmp++;
      if ({m0_ack, tmo, gnt, s_cyc} !== {1'b0, 1'b0, 2'b01, 1'b1}) begin
        n_bad++; $display("FAIL timeout_stall%0d got ack %b tmo %b gnt %b cyc %b exp 0 0 01 1", k, m0_ack, tmo, gnt, s_cyc);
      end
      tick();
    end
    #2;
    n_cmp++;
    if ({m0_ack, m0_data_s, tmo, s_cyc} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL timeout_abort got ack %b data %h tmo %b cyc %b exp 1 00 1 0", m0_ack, m0_data_s, tmo, s_cyc);
    end
    tick();
    #2;
    n_cmp++;
    if (gnt !== 2'b00 || tmo !== 1'b0) begin
      n_bad++; $display("FAIL timeout_after got gnt %b tmo %b exp 00 0", gnt, tmo);
    end
    idle_inputs();
    tick();
    tick();
  endtask
`endif

  task automatic test_random();
    logic [35:0] e;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 4) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 4) == 0) m1_cyc = ~m1_cyc;
      m0_stb = m0_cyc && ($urandom_range(0, 3) != 0);
      m1_stb = m1_cyc && ($urandom_range(0, 3) != 0);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_addr = AW'($urandom); m1_addr = AW'($urandom);
      m0_data_m = DW'($urandom); m1_data_m = DW'($urandom);
      s_ack = ($urandom_range(0, 3) == 0);
      s_data_s = DW'($urandom);
      #2;
      e = exp_vec();
      n_cmp++;
      if (act_vec() !== e) begin
        n_bad++; $display("FAIL random_c%0d got %h exp %h", c, act_vec(), e);
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_single_read();
    test_contention();
    test_locking();
    test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
